// File: rtl/matrix_frame_ctrl.sv
// Double-buffered 8x8 frame store with slot-aligned PWM output enable; swaps land only on slot ends.
// Latency: idle swap 1 cycle, scanning swap <= 8 cycles; writes accepted every cycle, no backpressure.
module matrix_frame_ctrl #(
    parameter int         ROWS         = 8,
    parameter logic [2:0] RESET_BRIGHT = 3'd7
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        wr_en_i,
    input  logic [2:0]  wr_addr_i,
    input  logic [7:0]  wr_data_i,
    input  logic        swap_req_i,
    input  logic        scan_en_i,
    input  logic [2:0]  brightness_i,
    output logic [63:0] frame_o,
    output logic        oe_o,
    output logic        swap_pending_o,
    output logic        swap_done_o,
    output logic        frame_tick_o
);

    localparam logic [2:0] LAST_ROW  = 3'(ROWS - 1);
    localparam logic [2:0] LAST_SLOT = 3'd7;

    logic [63:0] front_q, front_d;
    logic [63:0] back_q, back_d;
    logic [2:0]  row_cnt_q, row_cnt_d;
    logic [2:0]  slot_cnt_q, slot_cnt_d;
    logic [2:0]  bright_q, bright_d;
    logic        scan_active_q, scan_active_d;
    logic        pending_q, pending_d;
    logic        swap_done_q, swap_done_d;

    logic        row_last;
    logic        period_end;
    logic        swap_fire;

    always_comb begin
        row_last   = (row_cnt_q == LAST_ROW);
        period_end = scan_active_q & row_last & (slot_cnt_q == LAST_SLOT);
        // A request arriving on the swap edge itself is served by that edge.
        swap_fire  = (pending_q | swap_req_i) & (~scan_active_q | row_last);

        back_d = back_q;
        if (wr_en_i) begin
            back_d[{wr_addr_i, 3'b000} +: 8] = wr_data_i;
        end

        front_d       = swap_fire ? back_q : front_q;
        pending_d     = (pending_q | swap_req_i) & ~swap_fire;
        swap_done_d   = swap_fire;
        scan_active_d = scan_en_i;

        // Counters sit at zero whenever scanning is inactive, so a restart begins at row 0, slot 0.
        row_cnt_d  = 3'd0;
        slot_cnt_d = 3'd0;
        if (scan_active_q && scan_en_i) begin
            row_cnt_d  = row_cnt_q + 3'd1;
            slot_cnt_d = row_last ? slot_cnt_q + 3'd1 : slot_cnt_q;
        end

        bright_d = (~scan_active_q | period_end) ? brightness_i : bright_q;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            front_q       <= '0;
            back_q        <= '0;
            row_cnt_q     <= '0;
            slot_cnt_q    <= '0;
            bright_q      <= RESET_BRIGHT;
            scan_active_q <= 1'b0;
            pending_q     <= 1'b0;
            swap_done_q   <= 1'b0;
        end else begin
            front_q       <= front_d;
            back_q        <= back_d;
            row_cnt_q     <= row_cnt_d;
            slot_cnt_q    <= slot_cnt_d;
            bright_q      <= bright_d;
            scan_active_q <= scan_active_d;
            pending_q     <= pending_d;
            swap_done_q   <= swap_done_d;
        end
    end

    assign frame_o        = front_q;
    assign oe_o           = scan_active_q & (slot_cnt_q <= bright_q);
    assign swap_pending_o = pending_q;
    assign swap_done_o    = swap_done_q;
    assign frame_tick_o   = period_end;

endmodule

// File: doc/matrix_frame_ctrl.md
Name: matrix_frame_ctrl

Overview:
Frame and scan controller for the 8x8 LED matrix scanner. It holds a double-buffered 64-bit frame. The CPU writes one row byte at a time into the back buffer and requests a swap. The controller presents the front buffer on frame[63:0] and generates the scanner's oe with 8-clock-aligned windows, giving 8-level global brightness PWM. Swaps happen only at frame-slot boundaries, so no half-updated image is ever scanned.

Parameters:
ROWS, 8, rows per frame slot; fixed at 8, and the counters are sized for it.
RESET_BRIGHT, 7, brightness value loaded at reset (7 = full on).

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
wr_en  in  1  back-buffer byte write strobe
wr_addr  in  3  row index; row r = back[8r+7:8r]
wr_data  in  8  column byte
swap_req  in  1  one-cycle request: copy back buffer to front buffer at the next slot end
scan_en  in  1  scanning enable
brightness  in  3  on-slots per PWM period minus 1 (0 = 1/8, 7 = 8/8)
frame  out  64  front buffer, driven to the scanner data input
oe  out  1  scanner output enable
swap_pending  out  1  swap requested, not yet done
swap_done  out  1  one-cycle pulse in the cycle after a swap executes
frame_tick  out  1  one-cycle pulse at each PWM period end (row_cnt=7, slot_cnt=7)

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous and active-high, and dominates all other inputs.
- Reset values: front=0, back=0, bright_q=RESET_BRIGHT, row_cnt=0, slot_cnt=0, scan_active=0, pending=0. Outputs: frame=0, oe=0, swap_pending=0, swap_done=0, frame_tick=0.
- State: row_cnt[2:0], slot_cnt[2:0], scan_active, bright_q[2:0], pending, front[63:0], back[63:0].
- Writes: when wr_en=1, back[8*wr_addr +: 8] <= wr_data. Writes are accepted every cycle, with no backpressure.
- Scan enable: scan_active <= scan_en.
- Counters while scan_active=0: row_cnt=0, slot_cnt=0.
- Counters while scan_active=1: row_cnt increments every clock and wraps 7->0. slot_cnt increments when row_cnt=7 and wraps 7->0.
- oe is a combinational decode of registered state: oe = scan_active & (slot_cnt <= bright_q).
  - oe windows are therefore whole multiples of 8 clocks, starting at row_cnt=0. This keeps the scanner's row index aligned with each frame slot.
  - After scan_en is sampled high at edge N, oe=1 from edge N onward.
  - After scan_en is sampled low, oe=0 from the next edge, mid-slot if necessary.
- bright_q reload:
  - Loaded from brightness at the end of each PWM period (row_cnt=7, slot_cnt=7, scan_active=1).
  - Also loaded every cycle while scan_active=0.
  - Changing brightness mid-period has no effect until the period ends.
- frame_tick = scan_active & row_cnt==7 & slot_cnt==7 (combinational).
- Swap request: swap_req=1 sets pending. A further swap_req while pending is merged, giving one swap only.
- Swap point: the edge where pending|swap_req is 1 and either (scan_active=1 and row_cnt=7) or scan_active=0. At that edge: front <= back, pending <= 0, swap_done <= 1 for one cycle.
  - A swap_req arriving exactly at a swap point is served by that swap and does not leave pending set.
- Write coincident with swap: front receives the back value before the write. back receives the write.
- Boundary cases:
  - Scanning idle: a swap completes in 1 cycle.
  - Scanning: worst-case swap latency is 8 cycles.
  - scan_en dropping with a swap pending: the swap executes on the first idle cycle.
  - Reset mid-swap: the pending swap is discarded.
- frame = front, continuously.

Test Plan:
1. Reset, then scan_en=0; write rows 0..7 = 8'h01,02,04,...,80; pulse swap_req -> next edge frame=64'h8040201008040201, swap_done=1 for one cycle, swap_pending=0.
2. scan_en=1, brightness=7 -> oe=1 continuously. frame_tick pulses every 64 clocks, first at 63 clocks after scan_active rises.
3. brightness=2, scanning -> per 64-clock period oe is high for exactly 24 clocks (slots 0..2, starting at row_cnt=0), low for 40. Changing brightness to 5 mid-period -> the new duty (48/64) starts only after the next frame_tick.
4. Scanning, swap_req at row_cnt=2 -> swap_pending=1 for 5 cycles, swap at row_cnt=7 edge, frame updates as row_cnt wraps to 0. A second swap_req at row_cnt=4 produces no second swap_done.
5. Write row 3 = 8'hAA and swap_req in the same cycle at a swap point -> front row 3 holds the old value; a following swap yields 8'hAA in frame[31:24].
6. Assert reset while pending=1 and scanning -> next cycle oe=0, frame=0, swap_pending=0, no swap_done.
